spike_window_readout: RTL

Downstream of `Reservoir_crossbar`: consumes its per-timestep `spike_record` vector and accumulates a per-neuron spike count over a fixed window of reservoir timesteps. At window end it streams the counts out, one neuron per beat, over a valid/ready handshake. The readout/classifier stage uses these counts as its feature vector.

---
 rtl/reservoir_pkg.sv | 29 ++
 rtl/sat_counter.sv | 36 +++
 rtl/spike_window_readout.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/reservoir_pkg.sv
// Shared definitions for the reservoir readout path.
// Holds the default sizing of the spike-window readout, the readout FSM state
// type and a ceil-log2 helper used to size index and step counters.
package reservoir_pkg;

  localparam int unsigned NEURONS_DEFAULT   = 16;
  localparam int unsigned CNT_WIDTH_DEFAULT = 8;
  localparam int unsigned WINDOW_DEFAULT    = 64;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain
  } readout_state_t;

  // Ceil(log2(value)), never less than 1 so it can always size a vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter cell, one per reservoir neuron.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   clear            synchronous clear (wins over inc)
//   inc              add one, holding at all-ones instead of wrapping
//   count            current count
//   count_next       value the count takes at the next edge
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next
);

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else if (inc && (count != '1)) begin
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/spike_window_readout.sv
// Spike-window readout: counts spikes per neuron over WINDOW reservoir steps,
// then streams the counts out one neuron per beat on a valid/ready handshake.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   start                 pulse in IDLE: clear counters and open a window
//   step_valid            reservoir step complete, spike_record valid
//   spike_record          per-neuron spike flags, index 0 = neuron 0
//   busy                  window open or draining
//   out_valid/out_ready   beat handshake
//   out_index/out_count   neuron number and its count for the current beat
//   out_last              beat for the final neuron
//   window_done           one-cycle pulse after the final beat is accepted
//   overrun               sticky: step_valid seen outside accumulation
module spike_window_readout
  import reservoir_pkg::*;
#(
  parameter int unsigned NEURONS   = NEURONS_DEFAULT,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT,
  parameter int unsigned WINDOW    = WINDOW_DEFAULT,
  localparam int unsigned IDX_W    = clog2(NEURONS),
  localparam int unsigned STEP_W   = clog2(WINDOW + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 step_valid,
  input  logic [0:NEURONS-1]   spike_record,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_index,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_last,
  output logic                 window_done,
  output logic                 overrun
);

  readout_state_t state_q, state_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q    [NEURONS];
  logic [CNT_WIDTH-1:0] cnt_next [NEURONS];
  logic [NEURONS-1:0]   cnt_inc;

  logic open_window, take_step, last_step, beat_accept, last_beat;

  logic                 busy_d, valid_d, last_d, done_d, overrun_d;
  logic [IDX_W-1:0]     index_d;
  logic [CNT_WIDTH-1:0] count_d;

  assign open_window = (state_q == StIdle) && start;
  assign take_step   = (state_q == StAccum) && step_valid;
  assign last_step   = take_step && (step_q == STEP_W'(WINDOW - 1));
  assign beat_accept = (state_q == StDrain) && out_valid && out_ready;
  assign last_beat   = beat_accept && (idx_q == IDX_W'(NEURONS - 1));

  for (genvar i = 0; i < NEURONS; i++) begin : g_cnt
    assign cnt_inc[i] = take_step && spike_record[i];

    sat_counter #(
      .WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .clear     (open_window),
      .inc       (cnt_inc[i]),
      .count     (cnt_q[i]),
      .count_next(cnt_next[i])
    );
  end

  always_comb begin
    step_d = step_q;
    if (open_window) begin
      step_d = '0;
    end else if (take_step) begin
      step_d = step_q + 1'b1;
    end
  end

  // The drain index parks at 0 outside DRAIN so the first beat is neuron 0.
  always_comb begin
    idx_d = idx_q;
    if (state_q != StDrain) begin
      idx_d = '0;
    end else if (beat_accept) begin
      idx_d = last_beat ? '0 : idx_q + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      step_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start)     state_d = StAccum;
      StAccum: if (last_step) state_d = StDrain;
      StDrain: if (last_beat) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs, computed one cycle ahead so every output leaves a flop.
  // On entry to DRAIN the counters are still absorbing the final step, so the
  // first beat takes neuron 0's next-state value.
  always_comb begin
    busy_d    = (state_d != StIdle);
    valid_d   = (state_d == StDrain);
    index_d   = idx_d;
    last_d    = (state_d == StDrain) && (idx_d == IDX_W'(NEURONS - 1));
    done_d    = last_beat;
    count_d   = '0;
    if (state_d == StDrain) begin
      count_d = (state_q == StDrain) ? cnt_q[idx_d] : cnt_next[0];
    end
    overrun_d = overrun;
    if (open_window) begin
      overrun_d = 1'b0;
    end else if (step_valid && (state_q != StAccum)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_index   <= '0;
      out_count   <= '0;
      out_last    <= 1'b0;
      window_done <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      busy        <= busy_d;
      out_valid   <= valid_d;
      out_index   <= index_d;
      out_count   <= count_d;
      out_last    <= last_d;
      window_done <= done_d;
      overrun     <= overrun_d;
    end
  end

endmodule
